// File: rtl/mux_sel_arbiter.sv
// -----------------------------------------------------------------------------
// mux_sel_arbiter
//
// Round-robin arbiter that shares one 8-input datapath mux among 8 requesters.
// It drives the mux selector and issues a registered one-hot grant. An owner
// keeps the grant while it requests. If others are waiting, the owner is
// pre-empted after MAX_HOLD consecutive grant cycles. Every hand-over inserts
// one turnaround cycle (TURN). During TURN no grant is active, and the selector
// keeps the last owner so the mux output stays stable.
//
// Ports:
//   clk          system clock, rising edge
//   reset        asynchronous, active-high reset
//   req[7:0]     level-sensitive request vector, bit i = requester i
//   grant[7:0]   registered one-hot grant, all-zero when there is no owner
//   selector[2:0] registered mux select, index of the current or last owner
//   grant_valid  registered, high while grant is non-zero
//   busy         registered, high in GRANT or TURN
// -----------------------------------------------------------------------------
module mux_sel_arbiter #(
   parameter int NREQ      = 8,
   parameter int SEL_WIDTH = 3,
   parameter int MAX_HOLD  = 16
) (
   input  logic                 clk,
   input  logic                 reset,
   input  logic [NREQ-1:0]      req,
   output logic [NREQ-1:0]      grant,
   output logic [SEL_WIDTH-1:0] selector,
   output logic                 grant_valid,
   output logic                 busy
);

   // The hold counter only has to reach MAX_HOLD-1.
   localparam int HCNT_W = (MAX_HOLD > 1) ? $clog2(MAX_HOLD) : 1;
   localparam logic [HCNT_W-1:0]    HOLD_LAST = (MAX_HOLD > 0) ? HCNT_W'(MAX_HOLD - 1) : '0;
   localparam logic [NREQ-1:0]      ONE_HOT0  = NREQ'(1);
   localparam logic [SEL_WIDTH-1:0] SEL_ONE   = SEL_WIDTH'(1);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      GRANT = 2'd1,
      TURN  = 2'd2
   } state_t;

   state_t                state_q, state_d;
   logic [NREQ-1:0]       grant_q, grant_d;
   logic [SEL_WIDTH-1:0]  selector_q, selector_d;
   logic [SEL_WIDTH-1:0]  ptr_q, ptr_d;
   logic [HCNT_W-1:0]     hcnt_q, hcnt_d;
   logic                  grant_valid_q, grant_valid_d;
   logic                  busy_q, busy_d;

   logic [SEL_WIDTH-1:0]  win;
   logic                  owner_req;
   logic                  others_waiting;
   logic                  preempt;

   // Pick the first requester at or after 'start', wrapping modulo NREQ.
   // The selector width makes the index arithmetic wrap on its own.
   function automatic logic [SEL_WIDTH-1:0] pick_winner(
      input logic [NREQ-1:0]      r,
      input logic [SEL_WIDTH-1:0] start
   );
      logic [SEL_WIDTH-1:0] idx;
      logic [SEL_WIDTH-1:0] best;
      logic                 found;
      best  = start;
      found = 1'b0;
      for (int k = 0; k < NREQ; k++) begin
         idx = start + SEL_WIDTH'(k);
         if (!found && r[idx]) begin
            best  = idx;
            found = 1'b1;
         end
      end
      return best;
   endfunction

   always_comb begin
      // NOTE: every signal written here gets a default first. Any path that
      // leaves one unassigned would infer a latch.
      state_d        = state_q;
      grant_d        = grant_q;
      selector_d     = selector_q;
      ptr_d          = ptr_q;
      hcnt_d         = hcnt_q;

      win            = pick_winner(req, ptr_q);
      owner_req      = req[selector_q];
      others_waiting = |(req & ~grant_q);
      // Pre-emption fires only after a full hold window while someone else
      // waits. A sole requester keeps the bus indefinitely.
      preempt        = (MAX_HOLD != 0) && (hcnt_q == HOLD_LAST) && others_waiting;

      unique case (state_q)
         IDLE: begin
            if (|req) begin
               state_d    = GRANT;
               grant_d    = ONE_HOT0 << win;
               selector_d = win;
               hcnt_d     = '0;
            end
         end

         GRANT: begin
            // Release and pre-emption lead to the same place. An owner that
            // drops its request just as pre-emption fires is a plain release.
            if (!owner_req || preempt) begin
               state_d = TURN;
               grant_d = '0;
               ptr_d   = selector_q + SEL_ONE;   // old owner gets lowest priority
               hcnt_d  = '0;
            end else if ((MAX_HOLD != 0) && (hcnt_q != HOLD_LAST)) begin
               hcnt_d = hcnt_q + HCNT_W'(1);
            end
         end

         TURN: begin
            // selector is left alone so the mux keeps the last owner's data.
            if (|req) begin
               state_d    = GRANT;
               grant_d    = ONE_HOT0 << win;
               selector_d = win;
               hcnt_d     = '0;
            end else begin
               state_d = IDLE;
            end
         end

         default: begin
            state_d    = IDLE;
            grant_d    = '0;
            selector_d = '0;
            hcnt_d     = '0;
         end
      endcase

      grant_valid_d = |grant_d;
      busy_d        = (state_d != IDLE);
   end

   // NOTE: sequential state uses non-blocking assignments only. That way every
   // flop samples its pre-edge value, no matter what order the statements are in.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q       <= IDLE;
         grant_q       <= '0;
         selector_q    <= '0;
         ptr_q         <= '0;
         hcnt_q        <= '0;
         grant_valid_q <= 1'b0;
         busy_q        <= 1'b0;
      end else begin
         state_q       <= state_d;
         grant_q       <= grant_d;
         selector_q    <= selector_d;
         ptr_q         <= ptr_d;
         hcnt_q        <= hcnt_d;
         grant_valid_q <= grant_valid_d;
         busy_q        <= busy_d;
      end
   end

   assign grant       = grant_q;
   assign selector    = selector_q;
   assign grant_valid = grant_valid_q;
   assign busy        = busy_q;

endmodule
